// File: rtl/rgb_led_ctrl_pkg.sv
// Shared colour constants, display-mode encodings and the switch-index to colour map
// used by the RGB LED controller.
package rgb_led_ctrl_pkg;

  // {R,G,B}, 1 = lit
  localparam logic [2:0] WHITE  = 3'b111;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] OFF    = 3'b000;

  typedef enum logic [1:0] {
    MODE_STEADY = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_DIM    = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  function automatic logic [2:0] colour_map(input logic [1:0] idx);
    logic [2:0] c;
    case (idx)
      2'b00:   c = WHITE;
      2'b01:   c = RED;
      2'b10:   c = GREEN;
      default: c = YELLOW;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rgb_led_ctrl_sw_debounce.sv
// Two-flop synchroniser plus stability counter for one W-bit switch field; the
// stable value only follows the input after DEB_CYCLES consecutive differing cycles.
module sw_debounce #(
  parameter int W          = 2,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] sw_i,
  output logic [W-1:0] stable_o
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [W-1:0]     sync1;
  logic [W-1:0]     sync2;
  logic [W-1:0]     stable_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1    <= '0;
      sync2    <= '0;
      stable_q <= '0;
      cnt      <= '0;
    end else begin
      sync1 <= sw_i;
      sync2 <= sync1;
      // any cycle of agreement restarts the stability window
      if (sync2 != stable_q) begin
        if (cnt == CNT_LAST) begin
          stable_q <= sync2;
          cnt      <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/rgb_led_ctrl.sv
// Multi-channel RGB LED controller: debounced per-channel colour select with a shared
// steady / blink / PWM-dim / off display mode and registered LED outputs.
module rgb_led_ctrl
  import rgb_led_ctrl_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int PWM_W      = 8,
  parameter int BLINK_DIV  = 25000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [2*NUM_CH-1:0] sw_i,
  input  logic [1:0]          mode_i,
  input  logic [PWM_W-1:0]    duty_i,
  output logic [3*NUM_CH-1:0] rgb_o
);

  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [NUM_CH-1:0][1:0] stable_idx;
  mode_e                  mode_q;
  logic [BLINK_W-1:0]     blink_cnt;
  logic                   blink_phase;
  logic [PWM_W-1:0]       pwm_cnt;
  logic [PWM_W-1:0]       duty_q;
  logic                   pwm_on;
  logic [3*NUM_CH-1:0]    rgb_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sw_debounce #(
      .W          (2),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .sw_i     (sw_i[2*g +: 2]),
      .stable_o (stable_idx[g])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q <= MODE_STEADY;
    end else begin
      mode_q <= mode_e'(mode_i);
    end
  end

  // entry into blink is detected on the raw input so the first visible blink cycle is on
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (mode_e'(mode_i) == MODE_BLINK && mode_q != MODE_BLINK) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // duty is only reloaded at the period boundary to avoid mid-period glitches
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (&pwm_cnt) begin
        duty_q <= duty_i;
      end
    end
  end

  assign pwm_on = (pwm_cnt < duty_q);

  always_comb begin
    rgb_d = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      case (mode_q)
        MODE_STEADY: rgb_d[3*n +: 3] = colour_map(stable_idx[n]);
        MODE_BLINK:  rgb_d[3*n +: 3] = colour_map(stable_idx[n]) & {3{blink_phase}};
        MODE_DIM:    rgb_d[3*n +: 3] = colour_map(stable_idx[n]) & {3{pwm_on}};
        MODE_OFF:    rgb_d[3*n +: 3] = OFF;
        default:     rgb_d[3*n +: 3] = OFF;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rgb_o <= '0;
    end else begin
      rgb_o <= rgb_d;
    end
  end

endmodule

// File: tb/tb_rgb_led_ctrl.sv
// Directed self-checking bench for rgb_led_ctrl with NUM_CH=2, PWM_W=4, BLINK_DIV=4,
// DEB_CYCLES=4; rgb_o is {ch1 RGB, ch0 RGB}.
module tb_rgb_led_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] sw_i;
  logic [1:0] mode_i;
  logic [3:0] duty_i;
  logic [5:0] rgb_o;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  rgb_led_ctrl #(
    .NUM_CH     (2),
    .PWM_W      (4),
    .BLINK_DIV  (4),
    .DEB_CYCLES (4)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sw_i   (sw_i),
    .mode_i (mode_i),
    .duty_i (duty_i),
    .rgb_o  (rgb_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic test_reset;
    rst_i  = 1'b0;
    sw_i   = 4'b0000;
    mode_i = 2'b00;
    duty_i = 4'd0;
    tick;
    tick;
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (rgb_o !== 6'b000000) begin
      failures++;
      $display("FAIL reset_async: got %b expected %b", rgb_o, 6'b000000);
    end
    @(posedge clk_i);
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    cyc = 0;
    checks++;
    if (rgb_o !== 6'b000000) begin
      failures++;
      $display("FAIL reset_hold: got %b expected %b", rgb_o, 6'b000000);
    end
    tick;
    checks++;
    if (rgb_o !== 6'b111111) begin
      failures++;
      $display("FAIL reset_first_edge: got %b expected %b", rgb_o, 6'b111111);
    end
  endtask

  task automatic test_debounce_latency;
    logic [5:0] exp;
    sw_i = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      tick;
      exp = (k == 7) ? 6'b111100 : 6'b111111;
      checks++;
      if (rgb_o !== exp) begin
        failures++;
        $display("FAIL deb_latency[%0d]: got %b expected %b", k, rgb_o, exp);
      end
    end
  endtask

  task automatic test_bounce_reject;
    sw_i = 4'b1001;
    for (int k = 0; k < 23; k++) begin
      if (k == 3) sw_i = 4'b0001;
      tick;
      checks++;
      if (rgb_o !== 6'b111100) begin
        failures++;
        $display("FAIL bounce_reject[%0d]: got %b expected %b", k, rgb_o, 6'b111100);
      end
    end
  endtask

  task automatic blink_entry(input int n);
    logic [5:0] exp;
    mode_i = 2'b01;
    tick;
    checks++;
    if (rgb_o !== 6'b111100) begin
      failures++;
      $display("FAIL blink_entry_lag: got %b expected %b", rgb_o, 6'b111100);
    end
    for (int i = 0; i < n; i++) begin
      tick;
      exp = (((i / 4) % 2) == 0) ? 6'b111100 : 6'b000000;
      checks++;
      if (rgb_o !== exp) begin
        failures++;
        $display("FAIL blink[%0d]: got %b expected %b", i, rgb_o, exp);
      end
    end
  endtask

  task automatic test_blink;
    blink_entry(22);
    mode_i = 2'b00;
    tick;
    checks++;
    if (rgb_o !== 6'b000000) begin
      failures++;
      $display("FAIL blink_exit_lag: got %b expected %b", rgb_o, 6'b000000);
    end
    blink_entry(8);
  endtask

  task automatic test_dim;
    int unsigned eff;
    int unsigned p;
    logic [5:0]  exp;
    mode_i = 2'b10;
    duty_i = 4'd4;
    tick;
    for (int w = 0; w < 16 && (cyc % 16) != 0; w++) tick;
    eff = 4;
    for (int i = 0; i < 80; i++) begin
      if (i == 21) duty_i = 4'd12;
      if (i == 48) duty_i = 4'd0;
      tick;
      p   = (cyc - 1) % 16;
      exp = (p < eff) ? 6'b111100 : 6'b000000;
      checks++;
      if (rgb_o !== exp) begin
        failures++;
        $display("FAIL dim[%0d] pwm=%0d duty=%0d: got %b expected %b", i, p, eff, rgb_o, exp);
      end
      if (p == 15) eff = duty_i;
    end
  endtask

  task automatic test_off;
    mode_i = 2'b11;
    sw_i   = 4'b1101;
    for (int k = 0; k < 11; k++) begin
      tick;
      checks++;
      if (rgb_o !== 6'b000000) begin
        failures++;
        $display("FAIL off[%0d]: got %b expected %b", k, rgb_o, 6'b000000);
      end
    end
    mode_i = 2'b00;
    tick;
    checks++;
    if (rgb_o !== 6'b000000) begin
      failures++;
      $display("FAIL off_exit_lag: got %b expected %b", rgb_o, 6'b000000);
    end
    tick;
    checks++;
    if (rgb_o !== 6'b110100) begin
      failures++;
      $display("FAIL off_change_shown: got %b expected %b", rgb_o, 6'b110100);
    end
  endtask

  task automatic test_simultaneous;
    logic [5:0] exp;
    sw_i = 4'b1011;
    for (int k = 1; k <= 7; k++) begin
      tick;
      exp = (k == 7) ? 6'b010110 : 6'b110100;
      checks++;
      if (rgb_o !== exp) begin
        failures++;
        $display("FAIL simultaneous[%0d]: got %b expected %b", k, rgb_o, exp);
      end
    end
  endtask

  task automatic test_reset_mid_blink;
    logic [5:0] exp;
    mode_i = 2'b01;
    sw_i   = 4'b0101;
    for (int k = 0; k < 5; k++) tick;
    checks++;
    if (rgb_o !== 6'b010110) begin
      failures++;
      $display("FAIL pre_reset_blink: got %b expected %b", rgb_o, 6'b010110);
    end
    #1 rst_i = 1'b1;
    #1;
    checks++;
    if (rgb_o !== 6'b000000) begin
      failures++;
      $display("FAIL reset_mid_blink: got %b expected %b", rgb_o, 6'b000000);
    end
    mode_i = 2'b00;
    @(posedge clk_i);
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 7; k++) begin
      tick;
      exp = (k == 7) ? 6'b100100 : 6'b111111;
      checks++;
      if (rgb_o !== exp) begin
        failures++;
        $display("FAIL post_reset[%0d]: got %b expected %b", k, rgb_o, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_debounce_latency;
    test_bounce_reject;
    test_blink;
    test_dim;
    test_off;
    test_simultaneous;
    test_reset_mid_blink;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
